// File: rtl/sa_feeder_pkg.sv
// sa_feeder_pkg: shared definitions for the systolic-array feeder.
//   feed_state_t : job sequencing states of the feeder.
//   drain_len()  : number of zero shifts needed after the last data vector
//                  so that every skewed lane has presented it to the array.
package sa_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // The deepest lane (index max(rows,cols)-1) lags lane 0 by that many shifts.
  function automatic int drain_len(input int rows, input int cols);
    return ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/sa_feeder_skew.sv
// skew_line: shift-enabled delay line for one array lane.
//   Holds DEPTH+1 registers; O_Q shows the value written DEPTH shifts
//   before the most recent shift (DEPTH=0 is a single register).
// Ports:
//   I_CLK       rising-edge clock
//   I_ASYN_RSTN asynchronous active-low clear
//   I_SYNC_RSTN synchronous active-low clear
//   I_SHIFT     advance strobe; the line holds when low
//   I_D         lane input (D_W bits)
//   O_Q         delayed lane output (D_W bits)
module skew_line #(
  parameter int D_W   = 16,
  parameter int DEPTH = 0
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RSTN,
  input  logic           I_SYNC_RSTN,
  input  logic           I_SHIFT,
  input  logic [D_W-1:0] I_D,
  output logic [D_W-1:0] O_Q
);

  logic [D_W-1:0] taps [DEPTH+1];

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      for (int k = 0; k <= DEPTH; k++) taps[k] <= '0;
    end else if (!I_SYNC_RSTN) begin
      for (int k = 0; k <= DEPTH; k++) taps[k] <= '0;
    end else if (I_SHIFT) begin
      taps[0] <= I_D;
      for (int k = 1; k <= DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

  assign O_Q = taps[DEPTH];

endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: buffers (X column, W row) vector pairs and presents them to a
// systolic array with the diagonal skew the array expects.
// Ports:
//   I_CLK, I_ASYN_RSTN (async, active-low), I_SYNC_RSTN (sync, active-low)
//   I_START, I_K       job start request and number of k-vectors
//   I_VLD, O_RDY       vector handshake (accepted when both high)
//   I_X_VEC, I_W_VEC   X column (SA_R lanes) and W row (SA_C lanes)
//   I_SHIFT            array advance strobe
//   O_SA_START         one-cycle pulse to the array when a job starts
//   O_X, O_W           skewed lanes; lane i lags lane 0 by i shifts
//   O_BUSY, O_DONE     job active / one-cycle completion pulse
//   O_UNDERFLOW        sticky: a shift found no vector and a bubble was sent
module sa_feeder
  import sa_feeder_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int K_W  = 8
) (
  input  logic                  I_CLK,
  input  logic                  I_ASYN_RSTN,
  input  logic                  I_SYNC_RSTN,
  input  logic                  I_START,
  input  logic [K_W-1:0]        I_K,
  input  logic                  I_VLD,
  output logic                  O_RDY,
  input  logic [SA_R*D_W-1:0]   I_X_VEC,
  input  logic [SA_C*D_W-1:0]   I_W_VEC,
  input  logic                  I_SHIFT,
  output logic                  O_SA_START,
  output logic [SA_R*D_W-1:0]   O_X,
  output logic [SA_C*D_W-1:0]   O_W,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_UNDERFLOW
);

  localparam int DRAIN_N = drain_len(SA_R, SA_C);
  localparam int DC_W    = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'((DRAIN_N > 0) ? DRAIN_N - 1 : 0);

  feed_state_t          state;
  logic [K_W-1:0]       k_len;
  logic [K_W-1:0]       k_cnt;
  logic [K_W-1:0]       acc_cnt;
  logic [DC_W-1:0]      drain_cnt;
  logic                 hold_full;
  logic [SA_R*D_W-1:0]  hold_x;
  logic [SA_C*D_W-1:0]  hold_w;
  logic                 sa_start_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 underflow_q;

  logic accept;
  logic advance;
  logic consume;

  assign O_RDY   = (state == FEED) && !hold_full && (acc_cnt < k_len);
  assign accept  = I_VLD & O_RDY;
  // Skew lines move with every array shift while a job is active; a shift
  // with nothing to consume still advances them, pushing a zero bubble.
  assign advance = I_SHIFT & ((state == FEED) | (state == DRAIN));
  assign consume = I_SHIFT & (state == FEED) & hold_full;

  // Job sequencing and registered status outputs
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state       <= IDLE;
      k_len       <= '0;
      k_cnt       <= '0;
      acc_cnt     <= '0;
      drain_cnt   <= '0;
      hold_full   <= 1'b0;
      sa_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      state       <= IDLE;
      k_len       <= '0;
      k_cnt       <= '0;
      acc_cnt     <= '0;
      drain_cnt   <= '0;
      hold_full   <= 1'b0;
      sa_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sa_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START && (I_K != '0)) begin
            state       <= FEED;
            k_len       <= I_K;
            k_cnt       <= '0;
            acc_cnt     <= '0;
            underflow_q <= 1'b0;
            sa_start_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        FEED: begin
          if (accept) acc_cnt <= acc_cnt + K_W'(1);
          // The shift sees the register as it was before this edge's accept.
          if (accept)       hold_full <= 1'b1;
          else if (consume) hold_full <= 1'b0;
          if (I_SHIFT) begin
            if (hold_full) begin
              k_cnt <= k_cnt + K_W'(1);
              if (k_cnt + K_W'(1) == k_len) begin
                drain_cnt <= '0;
                if (DRAIN_N == 0) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  state <= DRAIN;
                end
              end
            end else begin
              underflow_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (I_SHIFT) begin
            if (drain_cnt == DRAIN_LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DC_W'(1);
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry holding register
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      hold_x <= '0;
      hold_w <= '0;
    end else if (!I_SYNC_RSTN) begin
      hold_x <= '0;
      hold_w <= '0;
    end else if (accept) begin
      hold_x <= I_X_VEC;
      hold_w <= I_W_VEC;
    end
  end

  // Skew lines: lane i is delayed by i shifts relative to lane 0
  for (genvar i = 0; i < SA_R; i++) begin : g_x
    skew_line #(.D_W(D_W), .DEPTH(i)) u_x (
      .I_CLK       (I_CLK),
      .I_ASYN_RSTN (I_ASYN_RSTN),
      .I_SYNC_RSTN (I_SYNC_RSTN),
      .I_SHIFT     (advance),
      .I_D         (consume ? hold_x[i*D_W +: D_W] : {D_W{1'b0}}),
      .O_Q         (O_X[i*D_W +: D_W])
    );
  end

  for (genvar j = 0; j < SA_C; j++) begin : g_w
    skew_line #(.D_W(D_W), .DEPTH(j)) u_w (
      .I_CLK       (I_CLK),
      .I_ASYN_RSTN (I_ASYN_RSTN),
      .I_SYNC_RSTN (I_SYNC_RSTN),
      .I_SHIFT     (advance),
      .I_D         (consume ? hold_w[j*D_W +: D_W] : {D_W{1'b0}}),
      .O_Q         (O_W[j*D_W +: D_W])
    );
  end

  assign O_SA_START  = sa_start_q;
  assign O_BUSY      = busy_q;
  assign O_DONE      = done_q;
  assign O_UNDERFLOW = underflow_q;

endmodule
